alu_cmd_sequencer: RTL
======================

# alu_cmd_sequencer

Command sequencer between UART_RX, ALU and UART_TX. Collects a three-byte command (operand A, operand B, opcode) from the receiver, validates it, drives the ALU operand/opcode registers, waits the ALU path latency, and launches exactly one response byte on the transmitter (result or error code). Adds inter-byte timeout, parity/opcode error reporting and overrun detection.

## Interface
- DATA_WIDTH, 8: operand/result width
- OP_WIDTH, 6: ALU opcode width
- ALU_LAT, 2: clock cycles from ALU input registers to valid result
- TIMEOUT_TICKS, 2048: max i_tick pulses allowed between command bytes
- ERR_PARITY, 8'hE1: response byte on parity error
- ERR_OPCODE, 8'hE2: response byte on invalid opcode

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_tick  in  1  baud-rate tick from BR_GENERATOR (timeout timebase)
- i_rx_done  in  1  one-cycle pulse, byte received
- i_rx_data  in  DATA_WIDTH  received byte, valid with i_rx_done
- i_rx_parity_err  in  1  parity error flag, valid with i_rx_done
- o_alu_datoa  out  DATA_WIDTH  ALU operand A
- o_alu_datob  out  DATA_WIDTH  ALU operand B
- o_alu_opcode  out  OP_WIDTH  ALU opcode
- i_alu_result  in  DATA_WIDTH  ALU result
- o_tx_data  out  DATA_WIDTH  response byte, stable from o_tx_start until i_tx_done
- o_tx_start  out  1  one-cycle pulse, start transmission
- i_tx_done  in  1  one-cycle pulse, transmission finished
- o_busy  out  1  high in every state except IDLE
- o_timeout  out  1  one-cycle pulse, partial command discarded
- o_overrun  out  1  sticky, byte arrived while not accepting; cleared only by reset

## Operation
- Reset: state IDLE; all outputs 0; timeout counter 0.
- States: IDLE, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
- IDLE: i_rx_done & !parity_err -> latch o_alu_datoa, go GET_B. With parity_err -> o_tx_data=ERR_PARITY, go SEND.
- GET_B: i_rx_done & !parity_err -> latch o_alu_datob, go GET_OP; parity_err -> ERR_PARITY, SEND.
- GET_OP: i_rx_done: parity_err -> ERR_PARITY, SEND; byte[7:6]!=0 or byte[5:0] not in {ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, NOR 6'h27, SRA 6'h03, SRL 6'h02} -> ERR_OPCODE, SEND (ALU opcode register unchanged); else latch o_alu_opcode, go EXEC.
- EXEC: stay ALU_LAT cycles (down-counter); on last cycle capture i_alu_result into o_tx_data, go SEND.
- SEND: o_tx_start=1 for this single cycle; go WAIT_TX.
- WAIT_TX: i_tx_done -> IDLE. i_tx_done in any other state ignored.
- Timeout: in GET_B/GET_OP counter increments per i_tick, clears on every accepted byte and on entering GET_B; reaching TIMEOUT_TICKS -> o_timeout pulse, go IDLE, no response sent.
- i_rx_done in EXEC/SEND/WAIT_TX: byte dropped, o_overrun set.
- Simultaneous i_rx_done and timeout terminal count: byte wins, counter cleared.
- Operands/result arithmetic: pass-through, no width change; opcode is byte[5:0].

## Timing
- i_rx_done at cycle t -> registers/state updated at edge ending t; new state visible t+1.
- Valid opcode at t: EXEC t+1..t+ALU_LAT, o_tx_start high at t+1+ALU_LAT (t+3 default).
- Error byte at t: o_tx_start high at t+1.
- o_tx_data changes only on entry to SEND; held through WAIT_TX.
- Reset asserted mid-command or mid-transmission: immediate return to IDLE, outputs 0, partial command lost; o_tx_start never glitches high.

## Structure
- Shared package alu_uart_pkg: state encoding localparams, opcode constants (ADD..SRL), ERR_PARITY/ERR_OPCODE defaults; reused by INTF and ALU benches.
- One sub-module: byte_timeout (tick counter with clear, enable, terminal-count pulse, parameter TIMEOUT_TICKS).

## Test plan
- Bytes 8'h02, 8'h04, 8'h20 -> ALU sees A=2,B=4,op=6'h20; o_tx_start at opcode_done+3 with o_tx_data=8'h06; i_tx_done -> o_busy=0.
- Bytes 8'h07, 8'h05, 8'h22 -> o_tx_data=8'h02; back-to-back second command 8'h0F,8'hF0,8'h25 -> 8'hFF.
- Opcode byte 8'h3F -> o_tx_data=8'hE2 at t+1, o_alu_opcode unchanged.
- Parity error on byte B -> o_tx_data=8'hE1, then IDLE; next clean command executes normally.
- A received, no further byte for TIMEOUT_TICKS ticks -> o_timeout pulse, no o_tx_start; byte arriving on terminal tick instead advances to GET_OP.
- Byte injected during WAIT_TX -> o_overrun=1 and stays; reset low mid-EXEC -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART/ALU command path: sequencer state encoding,
// ALU opcode constants and default error response bytes.
`default_nettype none

package alu_uart_pkg;

  localparam int DATA_WIDTH_DEF    = 8;
  localparam int OP_WIDTH_DEF      = 6;
  localparam int ALU_LAT_DEF       = 2;
  localparam int TIMEOUT_TICKS_DEF = 2048;

  localparam logic [7:0] ERR_PARITY_DEF = 8'hE1;
  localparam logic [7:0] ERR_OPCODE_DEF = 8'hE2;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_GET_B_ENC   = 3'd1;
  localparam logic [2:0] ST_GET_OP_ENC  = 3'd2;
  localparam logic [2:0] ST_EXEC_ENC    = 3'd3;
  localparam logic [2:0] ST_SEND_ENC    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX_ENC = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_GET_B   = ST_GET_B_ENC,
    ST_GET_OP  = ST_GET_OP_ENC,
    ST_EXEC    = ST_EXEC_ENC,
    ST_SEND    = ST_SEND_ENC,
    ST_WAIT_TX = ST_WAIT_TX_ENC
  } seq_state_t;

  function automatic logic is_valid_opcode(input logic [5:0] op);
    logic ok;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_timeout.sv
// Inter-byte tick counter: counts ticks while enabled, pulses expire on the tick
// that reaches TIMEOUT_TICKS. A clear in the same cycle suppresses the expiry.
`default_nettype none

module byte_timeout #(
  parameter int TIMEOUT_TICKS = 2048
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_TICKS + 1);

  logic [CW-1:0] count;

  assign expire = enable && tick && !clear && (count == CW'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (enable && tick) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// Collects A/B/opcode bytes from the UART receiver, drives the ALU registers and
// returns one response byte (result or error code) to the UART transmitter.
`default_nettype none

module alu_cmd_sequencer
  import alu_uart_pkg::*;
#(
  parameter int                    DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int                    OP_WIDTH      = OP_WIDTH_DEF,
  parameter int                    ALU_LAT       = ALU_LAT_DEF,
  parameter int                    TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter logic [DATA_WIDTH-1:0] ERR_PARITY    = DATA_WIDTH'(ERR_PARITY_DEF),
  parameter logic [DATA_WIDTH-1:0] ERR_OPCODE    = DATA_WIDTH'(ERR_OPCODE_DEF)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_parity_err,
  output logic [DATA_WIDTH-1:0] o_alu_datoa,
  output logic [DATA_WIDTH-1:0] o_alu_datob,
  output logic [OP_WIDTH-1:0]   o_alu_opcode,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_timeout,
  output logic                  o_overrun
);

  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  seq_state_t state, state_next;

  logic [LW-1:0]         lat_cnt, lat_next;
  logic [DATA_WIDTH-1:0] datoa_next, datob_next, tx_data_next;
  logic [OP_WIDTH-1:0]   opcode_next;
  logic                  overrun_next, timeout_next;
  logic                  collecting, tmo_expire, tmo_clear, opcode_ok;

  assign collecting = (state == ST_GET_B) || (state == ST_GET_OP);
  assign tmo_clear  = !collecting || i_rx_done;
  assign opcode_ok  = ((i_rx_data >> OP_WIDTH) == '0) &&
                      is_valid_opcode(6'(i_rx_data[OP_WIDTH-1:0]));

  byte_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_byte_timeout (
    .clk   (i_clock),
    .rst_n (i_reset),
    .clear (tmo_clear),
    .enable(collecting),
    .tick  (i_tick),
    .expire(tmo_expire)
  );

  always_comb begin
    state_next   = state;
    lat_next     = lat_cnt;
    datoa_next   = o_alu_datoa;
    datob_next   = o_alu_datob;
    opcode_next  = o_alu_opcode;
    tx_data_next = o_tx_data;
    timeout_next = 1'b0;
    overrun_next = o_overrun;

    case (state)
      ST_IDLE: begin
        if (i_rx_done) begin
          if (i_rx_parity_err) begin
            tx_data_next = ERR_PARITY;
            state_next   = ST_SEND;
          end else begin
            datoa_next = i_rx_data;
            state_next = ST_GET_B;
          end
        end
      end
      ST_GET_B: begin
        if (i_rx_done) begin
          if (i_rx_parity_err) begin
            tx_data_next = ERR_PARITY;
            state_next   = ST_SEND;
          end else begin
            datob_next = i_rx_data;
            state_next = ST_GET_OP;
          end
        end else if (tmo_expire) begin
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      ST_GET_OP: begin
        if (i_rx_done) begin
          if (i_rx_parity_err) begin
            tx_data_next = ERR_PARITY;
            state_next   = ST_SEND;
          end else if (opcode_ok) begin
            opcode_next = i_rx_data[OP_WIDTH-1:0];
            lat_next    = LW'(ALU_LAT - 1);
            state_next  = ST_EXEC;
          end else begin
            tx_data_next = ERR_OPCODE;
            state_next   = ST_SEND;
          end
        end else if (tmo_expire) begin
          timeout_next = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (lat_cnt == '0) begin
          tx_data_next = i_alu_result;
          state_next   = ST_SEND;
        end else begin
          lat_next = lat_cnt - 1'b1;
        end
      end
      ST_SEND:    state_next = ST_WAIT_TX;
      ST_WAIT_TX: if (i_tx_done) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase

    // Bytes landing while a command is in flight are dropped, not queued.
    if (i_rx_done && (state == ST_EXEC || state == ST_SEND || state == ST_WAIT_TX)) begin
      overrun_next = 1'b1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      lat_cnt      <= '0;
      o_alu_datoa  <= '0;
      o_alu_datob  <= '0;
      o_alu_opcode <= '0;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_busy       <= 1'b0;
      o_timeout    <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      lat_cnt      <= lat_next;
      o_alu_datoa  <= datoa_next;
      o_alu_datob  <= datob_next;
      o_alu_opcode <= opcode_next;
      o_tx_data    <= tx_data_next;
      o_tx_start   <= (state_next == ST_SEND);
      o_busy       <= (state_next != ST_IDLE);
      o_timeout    <= timeout_next;
      o_overrun    <= overrun_next;
    end
  end

endmodule

`default_nettype wire
